// File: rtl/dest_reg_scoreboard_pkg.sv
// Shared types and constants for the destination-register scoreboard:
// destination-kind codes, special register numbers and the pipeline slot record.
package dest_reg_scoreboard_pkg;

    typedef enum logic [1:0] {
        DST_RT  = 2'b00,
        DST_RD  = 2'b01,
        DST_RA  = 2'b10,
        DST_RSV = 2'b11
    } dst_kind_e;

    localparam logic [4:0] RA_REG   = 5'd31;
    localparam logic [4:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic       is_load;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '{valid: 1'b0, dst: ZERO_REG, is_load: 1'b0};

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } sb_state_e;

    // The reserved code behaves like rt so a stray encoding cannot corrupt the mux.
    function automatic dst_kind_e decode_kind(input logic [1:0] kind);
        dst_kind_e k;
        case (kind)
            2'b01:   k = DST_RD;
            2'b10:   k = DST_RA;
            default: k = DST_RT;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/dest_reg_scoreboard_if.sv
// ID-stage hazard interface: decoded instruction fields in, stall/mux select out.
interface dest_reg_scoreboard_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [4:0]       id_rd;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_reg_write;
    logic             id_mem_read;
    logic [1:0]       id_dst_kind;
    logic             flush;
    logic [1:0]       dst_sel;
    logic             stall;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
               id_reg_write, id_mem_read, id_dst_kind, flush,
        input  dst_sel, stall, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
               id_reg_write, id_mem_read, id_dst_kind, flush,
        output dst_sel, stall, stall_count
    );
endinterface

// File: rtl/dest_reg_scoreboard_sb_src_match.sv
// Compares one ID source operand against one tracked pipeline slot.
module sb_src_match
    import dest_reg_scoreboard_pkg::*;
(
    input  logic [4:0] src_i,
    input  logic       used_i,
    input  logic       slot_valid_i,
    input  logic [4:0] slot_dst_i,
    output logic       match_o
);

    // $0 is hardwired, so a read of it never depends on an older producer.
    assign match_o = slot_valid_i & used_i & (src_i != ZERO_REG) & (src_i == slot_dst_i);

endmodule

// File: rtl/dest_reg_scoreboard.sv
// Destination-register scoreboard: tracks EX/MEM/WB writers and raises a
// zero-latency stall on RAW hazards that forwarding cannot cover.
module dest_reg_scoreboard
    import dest_reg_scoreboard_pkg::*;
#(
    parameter int FORWARDING = 1,
    parameter int CNT_W      = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    dest_reg_scoreboard_if.slave sb_if
);

    slot_t            ex_q, ex_d;
    slot_t            mem_q;
    slot_t            wb_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dst_kind_e        dst_sel;
    logic [4:0]       id_dst;
    sb_state_e        state;
    logic             stall;
    logic             hazard;
    logic             ex_hit;
    logic             mem_hit;
    logic [4:0]       src     [2];
    logic [1:0]       src_used;
    slot_t            cmp_slot[2];
    logic [1:0][1:0]  hit;
    logic             wb_unused;

    assign dst_sel       = decode_kind(sb_if.id_dst_kind);
    assign sb_if.dst_sel = dst_sel;

    always_comb begin
        case (dst_sel)
            DST_RD:  id_dst = sb_if.id_rd;
            DST_RA:  id_dst = RA_REG;
            default: id_dst = sb_if.id_rt;
        endcase
    end

    assign src[0]      = sb_if.id_rs;
    assign src[1]      = sb_if.id_rt;
    assign src_used    = {sb_if.id_uses_rt, sb_if.id_uses_rs};
    assign cmp_slot[0] = ex_q;
    assign cmp_slot[1] = mem_q;

    // hit[slot][source]: slot 0 = EX, slot 1 = MEM
    for (genvar s = 0; s < 2; s++) begin : g_slot
        for (genvar p = 0; p < 2; p++) begin : g_src
            sb_src_match u_match (
                .src_i        (src[p]),
                .used_i       (src_used[p]),
                .slot_valid_i (cmp_slot[s].valid),
                .slot_dst_i   (cmp_slot[s].dst),
                .match_o      (hit[s][p])
            );
        end
    end

    always_comb begin
        ex_hit  = |hit[0];
        mem_hit = |hit[1];
        if (FORWARDING != 0) begin
            hazard = ex_hit & ex_q.is_load;
        end else begin
            hazard = ex_hit | mem_hit;
        end
        state = ST_RUN;
        if (sb_if.id_valid && !sb_if.flush && hazard) begin
            state = ST_HOLD;
        end
    end

    assign stall             = (state == ST_HOLD);
    assign sb_if.stall       = stall;
    assign sb_if.stall_count = cnt_q;

    always_comb begin
        ex_d = SLOT_EMPTY;
        if (!stall && !sb_if.flush) begin
            ex_d.valid   = sb_if.id_valid & sb_if.id_reg_write & (id_dst != ZERO_REG);
            ex_d.dst     = id_dst;
            ex_d.is_load = sb_if.id_mem_read;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_q  <= SLOT_EMPTY;
            mem_q <= SLOT_EMPTY;
            wb_q  <= SLOT_EMPTY;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            cnt_q <= cnt_d;
        end
    end

    // WB is tracked for completeness but the regfile writes early, so it never gates ID.
    assign wb_unused = ^wb_q;

endmodule

// File: tb/tb_dest_reg_scoreboard.sv
// Bench for dest_reg_scoreboard: three instances (forwarding, no forwarding,
// 4-bit counter) share one directed stimulus and are checked against a model.
module tb_dest_reg_scoreboard;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, flush;
    logic [4:0] id_rs, id_rt, id_rd;
    logic [1:0] id_dst_kind;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dest_reg_scoreboard_if #(.CNT_W(16)) bus_f1 ();
    dest_reg_scoreboard_if #(.CNT_W(16)) bus_f0 ();
    dest_reg_scoreboard_if #(.CNT_W(4))  bus_sat ();

    assign bus_f1.id_valid = id_valid;       assign bus_f0.id_valid = id_valid;       assign bus_sat.id_valid = id_valid;
    assign bus_f1.id_rs = id_rs;             assign bus_f0.id_rs = id_rs;             assign bus_sat.id_rs = id_rs;
    assign bus_f1.id_rt = id_rt;             assign bus_f0.id_rt = id_rt;             assign bus_sat.id_rt = id_rt;
    assign bus_f1.id_rd = id_rd;             assign bus_f0.id_rd = id_rd;             assign bus_sat.id_rd = id_rd;
    assign bus_f1.id_uses_rs = id_uses_rs;   assign bus_f0.id_uses_rs = id_uses_rs;   assign bus_sat.id_uses_rs = id_uses_rs;
    assign bus_f1.id_uses_rt = id_uses_rt;   assign bus_f0.id_uses_rt = id_uses_rt;   assign bus_sat.id_uses_rt = id_uses_rt;
    assign bus_f1.id_reg_write = id_reg_write; assign bus_f0.id_reg_write = id_reg_write; assign bus_sat.id_reg_write = id_reg_write;
    assign bus_f1.id_mem_read = id_mem_read; assign bus_f0.id_mem_read = id_mem_read; assign bus_sat.id_mem_read = id_mem_read;
    assign bus_f1.id_dst_kind = id_dst_kind; assign bus_f0.id_dst_kind = id_dst_kind; assign bus_sat.id_dst_kind = id_dst_kind;
    assign bus_f1.flush = flush;             assign bus_f0.flush = flush;             assign bus_sat.flush = flush;

    dest_reg_scoreboard #(.FORWARDING(1), .CNT_W(16)) u_f1 (.clk_i(clk), .rst_i(rst), .sb_if(bus_f1.slave));
    dest_reg_scoreboard #(.FORWARDING(0), .CNT_W(16)) u_f0 (.clk_i(clk), .rst_i(rst), .sb_if(bus_f0.slave));
    dest_reg_scoreboard #(.FORWARDING(1), .CNT_W(4))  u_sat (.clk_i(clk), .rst_i(rst), .sb_if(bus_sat.slave));

    logic        d_stall [3];
    logic [31:0] d_sel   [3];
    logic [31:0] d_cnt   [3];
    assign d_stall[0] = bus_f1.stall;  assign d_stall[1] = bus_f0.stall;  assign d_stall[2] = bus_sat.stall;
    assign d_sel[0] = 32'(bus_f1.dst_sel); assign d_sel[1] = 32'(bus_f0.dst_sel); assign d_sel[2] = 32'(bus_sat.dst_sel);
    assign d_cnt[0] = 32'(bus_f1.stall_count); assign d_cnt[1] = 32'(bus_f0.stall_count); assign d_cnt[2] = 32'(bus_sat.stall_count);

    // ---------------- behavioural model ----------------
    typedef struct { bit v; bit [4:0] d; bit ld; } ent_t;
    localparam bit MFWD [3] = '{1'b1, 1'b0, 1'b1};
    localparam int MMAX [3] = '{65535, 65535, 15};

    ent_t hist [3][3];   // [instance][age]: 0 = EX, 1 = MEM, 2 = WB
    int   mcnt [3];

    function automatic bit [4:0] m_dst();
        if (id_dst_kind == 2'b01) return id_rd;
        if (id_dst_kind == 2'b10) return 5'd31;
        return id_rt;
    endfunction

    function automatic int m_sel();
        return (id_dst_kind == 2'b11) ? 0 : int'(id_dst_kind);
    endfunction

    function automatic bit m_stall(int k);
        bit       hit;
        bit       used;
        bit [4:0] s;
        hit = 1'b0;
        if (rst || flush || !id_valid) return 1'b0;
        for (int p = 0; p < 2; p++) begin
            used = (p == 0) ? id_uses_rs : id_uses_rt;
            s    = (p == 0) ? id_rs : id_rt;
            if (used && s != 5'd0) begin
                if (hist[k][0].v && hist[k][0].d == s && (hist[k][0].ld || !MFWD[k])) hit = 1'b1;
                if (!MFWD[k] && hist[k][1].v && hist[k][1].d == s) hit = 1'b1;
            end
        end
        return hit;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                for (int a = 0; a < 3; a++) hist[k][a] <= '{1'b0, 5'd0, 1'b0};
                mcnt[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                hist[k][2] <= hist[k][1];
                hist[k][1] <= hist[k][0];
                if (m_stall(k) || flush)
                    hist[k][0] <= '{1'b0, 5'd0, 1'b0};
                else
                    hist[k][0] <= '{bit'(id_valid && id_reg_write && m_dst() != 5'd0), m_dst(), bit'(id_mem_read)};
                if (m_stall(k) && mcnt[k] < MMAX[k]) mcnt[k] <= mcnt[k] + 1;
            end
        end
    end

    task automatic chk(input string nm, input int k, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s inst%0d at %0t: got %0d, expected %0d", nm, k, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk("model_stall", k, int'(d_stall[k]), int'(m_stall(k)));
            chk("model_dstsel", k, int'(d_sel[k]), m_sel());
            chk("model_count", k, int'(d_cnt[k]), mcnt[k]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic setid(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd,
                         input bit urs, input bit urt, input bit rw, input bit mr,
                         input bit [1:0] kind, input bit fl);
        id_valid = v;  id_rs = rs;  id_rt = rt;  id_rd = rd;
        id_uses_rs = urs;  id_uses_rt = urt;  id_reg_write = rw;  id_mem_read = mr;
        id_dst_kind = kind;  flush = fl;
    endtask

    task automatic idle();
        setid(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic look();
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        nxt(); rst = 1'b1; idle();
        look();
        nxt(); rst = 1'b0;
    endtask

    initial begin
        // reset with a would-be hazard on the ID inputs
        setid(1, 8, 8, 0, 1, 1, 1, 1, 2'b00, 0);
        look();
        for (int k = 0; k < 3; k++) begin
            chk("reset_stall", k, int'(d_stall[k]), 0);
            chk("reset_count", k, int'(d_cnt[k]), 0);
        end
        nxt(); rst = 1'b0; idle();

        // load-use on $8
        do_reset();
        nxt(); setid(1, 2, 8, 0, 1, 0, 1, 1, 2'b00, 0);
        look(); chk("lu_pre_stall", 0, int'(d_stall[0]), 0);
        nxt(); setid(1, 8, 0, 3, 1, 0, 1, 0, 2'b01, 0);
        look(); chk("lu_stall", 0, int'(d_stall[0]), 1); chk("lu_stall", 1, int'(d_stall[1]), 1);
        nxt();
        look(); chk("lu_release", 0, int'(d_stall[0]), 0); chk("lu_count", 0, int'(d_cnt[0]), 1);
        chk("lu_nofwd_mem", 1, int'(d_stall[1]), 1);
        nxt();
        look(); chk("lu_nofwd_rel", 1, int'(d_stall[1]), 0); chk("lu_nofwd_cnt", 1, int'(d_cnt[1]), 2);
        nxt(); idle();

        // ALU RAW on $9 via rt
        do_reset();
        nxt(); setid(1, 1, 2, 9, 1, 1, 1, 0, 2'b01, 0);
        look();
        nxt(); setid(1, 0, 9, 4, 0, 1, 1, 0, 2'b01, 0);
        look(); chk("alu_fwd", 0, int'(d_stall[0]), 0); chk("alu_nofwd", 1, int'(d_stall[1]), 1);

        // no-forwarding back-to-back on $10
        do_reset();
        nxt(); setid(1, 1, 2, 10, 1, 1, 1, 0, 2'b01, 0);
        look();
        nxt(); setid(1, 10, 0, 5, 1, 0, 1, 0, 2'b01, 0);
        look(); chk("nf_c1", 1, int'(d_stall[1]), 1);
        nxt();
        look(); chk("nf_c2", 1, int'(d_stall[1]), 1);
        nxt();
        look(); chk("nf_wb_release", 1, int'(d_stall[1]), 0); chk("nf_count", 1, int'(d_cnt[1]), 2);
        chk("nf_fwd_count", 0, int'(d_cnt[0]), 0);

        // $0 writer, link and reserved destination kinds
        do_reset();
        nxt(); setid(1, 2, 0, 0, 1, 0, 1, 1, 2'b00, 0);
        look();
        nxt(); setid(1, 0, 0, 6, 1, 1, 1, 0, 2'b01, 0);
        look(); chk("zero_f1", 0, int'(d_stall[0]), 0); chk("zero_f0", 1, int'(d_stall[1]), 0);
        nxt(); setid(1, 0, 0, 0, 0, 0, 1, 0, 2'b10, 0);
        look(); chk("link_sel", 0, int'(d_sel[0]), 2);
        nxt(); setid(1, 31, 0, 7, 1, 0, 1, 0, 2'b01, 0);
        look(); chk("ra_nofwd", 1, int'(d_stall[1]), 1); chk("ra_fwd", 0, int'(d_stall[0]), 0);
        nxt(); idle();
        nxt(); setid(1, 3, 12, 20, 1, 0, 1, 1, 2'b11, 0);
        look(); chk("rsv_sel", 0, int'(d_sel[0]), 0);
        nxt(); setid(1, 12, 0, 21, 1, 0, 1, 0, 2'b01, 0);
        look(); chk("rsv_as_rt", 0, int'(d_stall[0]), 1);

        // flush during a load-use match
        do_reset();
        nxt(); setid(1, 2, 8, 0, 1, 0, 1, 1, 2'b00, 0);
        look();
        nxt(); setid(1, 8, 0, 3, 1, 0, 1, 0, 2'b01, 1);
        look(); for (int k = 0; k < 3; k++) chk("flush_stall", k, int'(d_stall[k]), 0);
        nxt(); setid(1, 8, 0, 3, 1, 0, 1, 0, 2'b01, 0);
        look(); chk("flush_bubble", 0, int'(d_stall[0]), 0); chk("flush_nofwd", 1, int'(d_stall[1]), 1);
        chk("flush_count", 0, int'(d_cnt[0]), 0);

        // reset pulse in the middle of a hold
        do_reset();
        nxt(); setid(1, 1, 2, 10, 1, 1, 1, 0, 2'b01, 0);
        look();
        nxt(); setid(1, 10, 0, 11, 1, 0, 1, 0, 2'b01, 0);
        look(); chk("rh_hold1", 1, int'(d_stall[1]), 1);
        nxt();
        look(); chk("rh_hold2", 1, int'(d_stall[1]), 1); chk("rh_cnt", 1, int'(d_cnt[1]), 1);
        #2 rst = 1'b1;
        #1 chk("rh_stall_drop", 1, int'(d_stall[1]), 0); chk("rh_cnt_clr", 1, int'(d_cnt[1]), 0);
        nxt(); rst = 1'b0;
        look(); for (int k = 0; k < 3; k++) chk("rh_after", k, int'(d_stall[k]), 0);
        nxt(); setid(1, 11, 0, 13, 1, 0, 1, 0, 2'b01, 0);
        look(); chk("rh_entered", 1, int'(d_stall[1]), 1);

        // saturation: lw $8,($8) held, stalls every other cycle
        do_reset();
        nxt(); setid(1, 8, 8, 0, 1, 0, 1, 1, 2'b00, 0);
        repeat (40) nxt();
        look(); chk("sat_count", 2, int'(d_cnt[2]), 15); chk("sat_wide", 0, int'(d_cnt[0]), 20);
        repeat (10) nxt();
        look(); chk("sat_nowrap", 2, int'(d_cnt[2]), 15); chk("sat_wide2", 0, int'(d_cnt[0]), 25);

        nxt(); idle();
        look();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
